// File: rtl/tdc_pkg.sv
// tdc_pkg: bus widths, default strobe timing and one-hot FSM encoding for the TDC read scheduler
package tdc_pkg;
  localparam int TDC_DATA_W      = 28;
  localparam int TDC_ADDR_W      = 4;
  localparam int TDC_SETUP_CYC   = 1;
  localparam int TDC_STROBE_CYC  = 2;
  localparam int TDC_RECOVER_CYC = 1;
  localparam int TDC_TIMEOUT     = 255;
  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_NOP     = 7'b0000010,
    ST_CHK     = 7'b0000100,
    ST_SETUP   = 7'b0001000,
    ST_STROBE  = 7'b0010000,
    ST_RECOVER = 7'b0100000,
    ST_DONE    = 7'b1000000
  } state_t;
  function automatic logic [7:0] phase_load(input state_t s, input int setup, input int strobe,
                                            input int recover, input int timeout);
    return (s == ST_CHK)     ? 8'(timeout)   :
           (s == ST_SETUP)   ? 8'(setup - 1)  :
           (s == ST_STROBE)  ? 8'(strobe - 1) :
           (s == ST_RECOVER) ? 8'(recover - 1) : 8'd0;
  endfunction
endpackage

// File: rtl/tdc_read_scheduler_if.sv
// tdc_read_scheduler_if: TDC pin bus plus valid/ready result channel
interface tdc_read_scheduler_if
  import tdc_pkg::*;
#(
  parameter int DATA_W = TDC_DATA_W,
  parameter int ADDR_W = TDC_ADDR_W
);
  logic [DATA_W-1:0] tdc_data;
  logic              tdc_ef1;
  logic [ADDR_W-1:0] tdc_addr;
  logic              tdc_csn;
  logic              tdc_rdn;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_addr;
  logic              res_valid;
  logic              res_ready;
  modport master (
    input  tdc_data, tdc_ef1, res_ready,
    output tdc_addr, tdc_csn, tdc_rdn, res_data, res_addr, res_valid
  );
  modport slave (
    output tdc_data, tdc_ef1, res_ready,
    input  tdc_addr, tdc_csn, tdc_rdn, res_data, res_addr, res_valid
  );
endinterface

// File: rtl/tdc_phase_cnt.sv
// tdc_phase_cnt: loadable 8-bit down counter timing every scheduler phase, saturating at zero
module tdc_phase_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_val,
  input  logic       i_dec,
  output logic       o_zero
);
  logic [7:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 8'd1;
  end
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/tdc_read_scheduler.sv
// tdc_read_scheduler: burst reader gating on EF1, timing CSN/RDN and buffering each word in a valid/ready slot
module tdc_read_scheduler
  import tdc_pkg::*;
#(
  parameter int DATA_W      = TDC_DATA_W,
  parameter int ADDR_W      = TDC_ADDR_W,
  parameter int SETUP_CYC   = TDC_SETUP_CYC,
  parameter int STROBE_CYC  = TDC_STROBE_CYC,
  parameter int RECOVER_CYC = TDC_RECOVER_CYC,
  parameter int TIMEOUT     = TDC_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   addr_first,
  input  logic [ADDR_W:0]     addr_count,
  tdc_read_scheduler_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_tdc_addr, r_res_addr;
  logic [ADDR_W:0]   r_left;
  logic [DATA_W-1:0] r_res_data;
  logic              r_csn, r_rdn, r_res_valid, r_busy, r_done, r_err;
  logic              w_zero, w_free, w_tmo, w_cap, w_load, w_dec;
  assign w_free = !r_res_valid || bus.res_ready;
  assign w_load = (w_next != r_state);
  assign w_dec  = (r_state == ST_CHK) ? bus.tdc_ef1 : (r_state inside {ST_SETUP, ST_STROBE, ST_RECOVER});
  tdc_phase_cnt u_phase (
    .clk    (clk),
    .rst    (reset),
    .i_load (w_load),
    .i_val  (phase_load(w_next, SETUP_CYC, STROBE_CYC, RECOVER_CYC, TIMEOUT)),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    w_cap  = 1'b0;
    unique case (r_state)
      ST_IDLE:    w_next = (start && !abort) ? ((addr_count == '0) ? ST_NOP : ST_CHK) : ST_IDLE;
      ST_NOP:     w_next = ST_DONE;
      ST_CHK: begin
        w_tmo  = bus.tdc_ef1 && w_zero;
        w_next = (!bus.tdc_ef1 && w_free) ? ST_SETUP : (w_tmo ? ST_DONE : ST_CHK);
      end
      ST_SETUP:   w_next = w_zero ? ST_STROBE : ST_SETUP;
      ST_STROBE: begin
        w_cap  = w_zero;
        w_next = w_zero ? ST_RECOVER : ST_STROBE;
      end
      ST_RECOVER: w_next = w_zero ? ((r_left == '0) ? ST_DONE : ST_CHK) : ST_RECOVER;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    // abort overrides everything, including a capture on the last strobe cycle
    if (abort && !(r_state inside {ST_IDLE, ST_DONE})) begin
      w_next = ST_DONE;
      w_tmo  = 1'b0;
      w_cap  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      r_tdc_addr  <= '0;
      r_csn       <= 1'b1;
      r_rdn       <= 1'b1;
      r_res_data  <= '0;
      r_res_addr  <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_csn   <= !(w_next inside {ST_SETUP, ST_STROBE});
      r_rdn   <= (w_next != ST_STROBE);
      r_busy  <= !(w_next inside {ST_IDLE, ST_DONE});
      r_done  <= (w_next == ST_DONE);
      r_err   <= w_tmo;
      if (r_state == ST_IDLE && w_next != ST_IDLE) begin
        r_addr <= addr_first;
        r_left <= addr_count;
      end
      if (w_next == ST_SETUP) r_tdc_addr <= r_addr;
      if (w_cap) begin
        r_res_data  <= bus.tdc_data;
        r_res_addr  <= r_addr;
        r_res_valid <= 1'b1;
        r_addr      <= r_addr + 1'b1;
        r_left      <= r_left - 1'b1;
      end else if (bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end
  assign bus.tdc_addr  = r_tdc_addr;
  assign bus.tdc_csn   = r_csn;
  assign bus.tdc_rdn   = r_rdn;
  assign bus.res_data  = r_res_data;
  assign bus.res_addr  = r_res_addr;
  assign bus.res_valid = r_res_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign timeout_err   = r_err;
endmodule

// File: tb/tb_tdc_read_scheduler.sv
// tb_tdc_read_scheduler: directed and randomized bursts against a memory-backed TDC model with a result scoreboard
module tb_tdc_read_scheduler;
  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] addr_first;
  logic [4:0] addr_count;
  logic       busy, done, timeout_err;
  tdc_read_scheduler_if bus();
  tdc_read_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .addr_first  (addr_first),
    .addr_count  (addr_count),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] a; logic [27:0] d;} exp_t;
  exp_t       q[$];
  logic [3:0] addr_log[$];
  logic [27:0] mem [16];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_strobe = 0, csn_run = 0, rdn_run = 0, s0;
  bit rdy_mode = 0, ef1_mode = 0, rdy_fixed = 1, ef1_fixed = 0, len_chk = 1;
  logic p_csn = 1'b1, p_rdn = 1'b1, p_ef1 = 1'b0, p_free = 1'b1;
  logic got_err, got_busy;
  assign bus.tdc_data = mem[bus.tdc_addr];
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always begin
    @(posedge clk);
    #2;
    bus.res_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
    bus.tdc_ef1   = ef1_mode ? ($urandom_range(0, 3) == 0) : ef1_fixed;
  end
  always @(negedge clk) begin
    if (!reset && bus.res_valid && bus.res_ready) begin
      check("word_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("res_addr", int'(bus.res_addr), int'(e.a));
        check("res_data", int'(bus.res_data), int'(e.d));
      end
    end
  end
  always @(negedge clk) begin
    if (!bus.tdc_csn) csn_run++;
    if (!bus.tdc_rdn) rdn_run++;
    if (!bus.tdc_rdn && p_rdn) begin
      n_strobe++;
      addr_log.push_back(bus.tdc_addr);
    end
    if (!bus.tdc_csn && p_csn) begin
      check("setup_after_ef1_low", int'(p_ef1), 0);
      check("setup_slot_free", int'(p_free), 1);
    end
    if (bus.tdc_csn && !p_csn) begin
      if (len_chk) begin
        check("csn_low_len", csn_run, 3);
        check("rdn_low_len", rdn_run, 2);
      end
      csn_run = 0;
      rdn_run = 0;
    end
    p_csn  = bus.tdc_csn;
    p_rdn  = bus.tdc_rdn;
    p_ef1  = bus.tdc_ef1;
    p_free = !bus.res_valid || bus.res_ready;
  end
  task automatic step();
    @(posedge clk);
    #1 cyc++;
  endtask
  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask
  task automatic push_words(input logic [3:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] a;
      a = f + 4'(i);
      q.push_back('{a, mem[a]});
    end
  endtask
  task automatic kick(input logic [3:0] f, input logic [4:0] n);
    addr_first = f;
    addr_count = n;
    @(posedge clk);
    #1 start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    while (!done && cyc < budget) step();
    check("done_seen", int'(done), 1);
    got_err  = timeout_err;
    got_busy = busy;
  endtask
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("queue_drained", q.size(), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; addr_first = '0; addr_count = '0;
    for (int i = 0; i < 16; i++) mem[i] = {24'($urandom), 4'(i)};
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn", int'(bus.tdc_csn), 1);
    check("rst_rdn", int'(bus.tdc_rdn), 1);
    check("rst_tdc_addr", int'(bus.tdc_addr), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_data", int'(bus.res_data), 0);
    check("rst_res_addr", int'(bus.res_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(timeout_err), 0);
    reset = 1'b0;
    s0 = n_strobe;
    push_words(4'h3, 2);
    kick(4'h3, 5'd2);
    check("t1_busy", int'(busy), 1);
    wait_done(100);
    check("t1_done_cyc", cyc, 11);
    check("t1_err", int'(got_err), 0);
    check("t1_busy_at_done", int'(got_busy), 0);
    check("t1_strobes", n_strobe - s0, 2);
    drain(50);
    addr_log.delete();
    push_words(4'hF, 3);
    kick(4'hF, 5'd3);
    wait_done(100);
    check("t2_done_cyc", cyc, 16);
    check("t2_log_len", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("t2_addr0", int'(addr_log[0]), 15);
      check("t2_addr1", int'(addr_log[1]), 0);
      check("t2_addr2", int'(addr_log[2]), 1);
    end
    drain(50);
    ef1_fixed = 1'b1;
    s0 = n_strobe;
    kick(4'h0, 5'd2);
    wait_done(400);
    check("t3_done_cyc", cyc, 257);
    check("t3_err", int'(got_err), 1);
    check("t3_busy", int'(got_busy), 0);
    check("t3_strobes", n_strobe - s0, 0);
    step();
    check("t3_err_pulse", int'(timeout_err), 0);
    ef1_fixed = 1'b0;
    rdy_fixed = 1'b0;
    s0 = n_strobe;
    push_words(4'h8, 3);
    kick(4'h8, 5'd3);
    while (!bus.res_valid && cyc < 50) step();
    check("t4_word1_valid", int'(bus.res_valid), 1);
    repeat (300) step();
    check("t4_parked_strobes", n_strobe - s0, 1);
    check("t4_parked_busy", int'(busy), 1);
    check("t4_no_err", int'(timeout_err), 0);
    rdy_fixed = 1'b1;
    wait_done(500);
    check("t4_err", int'(got_err), 0);
    check("t4_strobes", n_strobe - s0, 3);
    drain(50);
    len_chk = 1'b0;
    s0 = n_strobe;
    push_words(4'h5, 1);
    kick(4'h5, 5'd3);
    run_to(8);
    check("t5a_in_strobe", int'(bus.tdc_rdn), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5a_csn", int'(bus.tdc_csn), 1);
    check("t5a_rdn", int'(bus.tdc_rdn), 1);
    check("t5a_done", int'(done), 1);
    check("t5a_busy", int'(busy), 0);
    check("t5a_valid", int'(bus.res_valid), 0);
    check("t5a_strobes", n_strobe - s0, 2);
    step();
    len_chk = 1'b1;
    drain(20);
    kick(4'h9, 5'd1);
    run_to(4);
    check("t5b_last_strobe", int'(bus.tdc_rdn), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5b_done", int'(done), 1);
    check("t5b_no_capture", int'(bus.res_valid), 0);
    step();
    check("t5b_still_empty", int'(bus.res_valid), 0);
    rdy_fixed = 1'b0;
    push_words(4'hC, 1);
    kick(4'hC, 5'd2);
    run_to(5);
    check("t5c_pending", int'(bus.res_valid), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5c_done", int'(done), 1);
    check("t5c_kept_valid", int'(bus.res_valid), 1);
    check("t5c_kept_addr", int'(bus.res_addr), 12);
    rdy_fixed = 1'b1;
    drain(20);
    s0 = n_strobe;
    kick(4'h0, 5'd0);
    wait_done(20);
    check("t6_zero_done_cyc", cyc, 2);
    check("t6_zero_strobes", n_strobe - s0, 0);
    s0 = n_strobe;
    push_words(4'h2, 2);
    kick(4'h2, 5'd2);
    run_to(3);
    addr_first = 4'h7;
    addr_count = 5'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    check("t6_busy_start_done_cyc", cyc, 11);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6_start_in_done", int'(busy), 0);
    step();
    check("t6_start_in_done_2", int'(busy), 0);
    check("t6_busy_strobes", n_strobe - s0, 2);
    drain(20);
    len_chk = 1'b0;
    push_words(4'h4, 1);
    kick(4'h4, 5'd2);
    run_to(8);
    check("t6_rst_in_strobe", int'(bus.tdc_rdn), 0);
    reset = 1'b1;
    step();
    check("t6_rst_csn", int'(bus.tdc_csn), 1);
    check("t6_rst_rdn", int'(bus.tdc_rdn), 1);
    check("t6_rst_valid", int'(bus.res_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    reset = 1'b0;
    step();
    len_chk = 1'b1;
    rdy_fixed = 1'b0;
    kick(4'h1, 5'd1);
    wait_done(50);
    check("t6_pending_before_rst", int'(bus.res_valid), 1);
    reset = 1'b1;
    step();
    check("t6_rst_clears_valid", int'(bus.res_valid), 0);
    check("t6_rst_clears_data", int'(bus.res_data), 0);
    check("t6_rst_clears_addr", int'(bus.res_addr), 0);
    reset = 1'b0;
    rdy_fixed = 1'b1;
    step();
    rdy_mode = 1'b1;
    ef1_mode = 1'b1;
    for (int b = 0; b < 24; b++) begin
      logic [3:0] f;
      logic [4:0] n;
      for (int i = 0; i < 16; i++) mem[i] = {24'($urandom), 4'(i)};
      f = 4'($urandom);
      n = 5'($urandom_range(1, 16));
      push_words(f, int'(n));
      kick(f, n);
      wait_done(1500);
      check("rnd_err", int'(got_err), 0);
      check("rnd_busy", int'(got_busy), 0);
      drain(500);
    end
    rdy_mode = 1'b0;
    ef1_mode = 1'b0;
    repeat (5) step();
    check("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
